// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier_if
//  Description : Request/response bundle between the EX stage and the
//                sequential RV32M multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_multiplier_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] result;
    logic         busy;
    logic         done;

    // Requester side (EX-stage control)
    modport master (
        output start, op, a, b,
        input  result, busy, done
    );

    // Multiplier side
    modport slave (
        input  start, op, a, b,
        output result, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Radix-2 shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
//                Magnitudes are multiplied over N cycles and the 2N-bit
//                product is conditionally negated before the half is picked.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_multiplier #(
    parameter int N = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    seq_multiplier_if.slave  bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_last;

    logic [2*N-1:0]  r_p;
    logic [N-1:0]    r_mcand;
    logic [CW-1:0]   r_count;
    logic            r_neg;
    logic            r_hi;
    logic [N-1:0]    r_result;

    logic            w_sa;
    logic            w_sb;
    logic [N-1:0]    w_mcand_ld;
    logic [N-1:0]    w_mplier_ld;
    logic [N:0]      w_sum;
    logic [2*N-1:0]  w_p_next;
    logic [2*N-1:0]  w_prod;

    // Operand signs: a is signed for MULH/MULHSU, b only for MULH.
    assign w_sa        = bus.a[N-1] & (bus.op == 2'b01 || bus.op == 2'b10);
    assign w_sb        = bus.b[N-1] & (bus.op == 2'b01);
    // Magnitude of -2^(N-1) wraps to itself, which is correct as unsigned.
    assign w_mcand_ld  = w_sa ? (~bus.a + {{(N-1){1'b0}}, 1'b1}) : bus.a;
    assign w_mplier_ld = w_sb ? (~bus.b + {{(N-1){1'b0}}, 1'b1}) : bus.b;

    // One add-and-shift step; the adder carry becomes the new top bit.
    assign w_sum    = {1'b0, r_p[2*N-1:N]} + {1'b0, (r_p[0] ? r_mcand : {N{1'b0}})};
    assign w_p_next = {w_sum, r_p[N-1:1]};
    assign w_prod   = r_neg ? (~w_p_next + {{(2*N-1){1'b0}}, 1'b1}) : w_p_next;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured when not iterating
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_count == CW'(N - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, capture result on last step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p      <= '0;
            r_mcand  <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_hi     <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_mcand <= w_mcand_ld;
            r_p     <= {{N{1'b0}}, w_mplier_ld};
            r_count <= '0;
            r_neg   <= w_sa ^ w_sb;
            r_hi    <= (bus.op != 2'b00);
        end else if (r_state == S_RUN) begin
            r_p     <= w_p_next;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_result <= r_hi ? w_prod[2*N-1:N] : w_prod[N-1:0];
            end
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Self-checking bench for seq_multiplier (N=32): vector table,
//                random vectors against a 64-bit reference, and handshake,
//                reset-abort and back-to-back sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_multiplier_if #(.N(N)) mif ();

    seq_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] sb_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference: sign/zero-extend to 64 bits and take the modular product.
    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Drive a one-cycle start; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input bit push);
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        if (push) sb_q.push_back(exp);
        @(negedge clk);
        mif.start = 1'b0;
        mif.op    = 2'($urandom_range(0, 3));
        mif.a     = $urandom;
        mif.b     = $urandom;
    endtask

    // Wait (bounded) for done starting from cycle cyc0; check latency,
    // busy during RUN, result hold during RUN and the scoreboard entry.
    task automatic wait_done(input string name, input int cyc0);
        int          cyc;
        bit          busy_ok;
        bit          held_ok;
        logic [31:0] held;
        logic [31:0] e;
        cyc     = cyc0;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        held    = mif.result;
        while (mif.done !== 1'b1 && cyc <= 200) begin
            if (mif.busy !== 1'b1) busy_ok = 1'b0;
            if (mif.result !== held) held_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({name, " done_cycle"}, 32'(cyc), 32'd33);
        chk({name, " busy_in_run"}, 32'(busy_ok), 32'd1);
        chk({name, " result_held"}, 32'(held_ok), 32'd1);
        chk({name, " busy_at_done"}, 32'(mif.busy), 32'd0);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s result: got 0x%08h, expected scoreboard entry (queue empty)",
                     name, mif.result);
        end else begin
            e = sb_q.pop_front();
            chk({name, " result"}, mif.result, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          ndone;

        mif.start = 1'b0;
        mif.op    = 2'b00;
        mif.a     = '0;
        mif.b     = '0;

        vecs[0] = '{2'b00, 32'd7,        32'd6,        32'd42};
        vecs[1] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[3] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[5] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[6] = '{2'b01, 32'h00000000, 32'h80000000, 32'h00000000};
        vecs[7] = '{2'b10, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[8] = '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[9] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset result", mif.result, 32'd0);
        chk("reset busy", 32'(mif.busy), 32'd0);
        chk("reset done", 32'(mif.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            wait_done($sformatf("vec%0d", i), 1);
            @(negedge clk);
            chk($sformatf("vec%0d done_pulse", i), 32'(mif.done), 32'd0);
        end

        // Random vectors against the 64-bit reference
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            issue(rop, ra, rb, model(rop, ra, rb), 1'b1);
            wait_done($sformatf("rnd%0d", i), 1);
            @(negedge clk);
        end

        // Start during RUN is ignored; original result arrives at cycle 33
        issue(2'b00, 32'd100, 32'd200, 32'd20000, 1'b1);
        repeat (4) @(negedge clk);
        mif.start = 1'b1;
        mif.op    = 2'b11;
        mif.a     = 32'h0000DEAD;
        mif.b     = 32'h0000BEEF;
        @(negedge clk);
        mif.start = 1'b0;
        wait_done("restart_ignored", 6);
        @(negedge clk);
        chk("restart_ignored no_second_run", 32'(mif.busy), 32'd0);

        // Reset in cycle 10 of RUN aborts the operation
        issue(2'b00, 32'd7, 32'd6, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(mif.busy), 32'd0);
        chk("abort done", 32'(mif.done), 32'd0);
        chk("abort result", mif.result, 32'd0);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        wait_done("after_abort", 1);
        @(negedge clk);

        // Back-to-back: second start asserted in the DONE cycle
        issue(2'b00, 32'd7, 32'd6, 32'd42, 1'b1);
        wait_done("b2b_first", 1);
        issue(2'b11, 32'd3, 32'd5, 32'd0, 1'b1);
        chk("b2b busy_next", 32'(mif.busy), 32'd1);
        chk("b2b first_visible", mif.result, 32'd42);
        wait_done("b2b_second", 1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
